// File: rtl/debounce_bank_if.sv
// Handshake-free bundle between the debounce bank and its consumer.
// Master drives raw inputs and controls; slave returns conditioned state.
interface debounce_bank_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] dirty;
  logic [CHANNELS-1:0] rise_en;
  logic [CHANNELS-1:0] fall_en;
  logic [CHANNELS-1:0] irq_mask;
  logic [CHANNELS-1:0] clear;
  logic [CHANNELS-1:0] clean;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] pending;
  logic                irq;

  modport master (
    output dirty, rise_en, fall_en, irq_mask, clear,
    input  clean, rise, fall, pending, irq
  );

  modport slave (
    input  dirty, rise_en, fall_en, irq_mask, clear,
    output clean, rise, fall, pending, irq
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel input conditioner: synchroniser, debounce filter,
// edge pulses, sticky event latches and a masked interrupt.
module debounce_bank #(
  parameter int                  CHANNELS      = 8,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  STABLE_CYCLES = 50000,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
  input  logic            clk,
  input  logic            rst,
  debounce_bank_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0] clean_q, clean_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic                irq_q, irq_d;
  logic [CHANNELS-1:0] sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift raw inputs through the synchroniser chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.dirty;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Accept a new level only after an unbroken run of mismatches;
  // edges, latches and irq are all derived from the next clean value.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sync_s[c] == clean_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == LAST) begin
        clean_d[c] = sync_s[c];
        cnt_d[c]   = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
    rise_d    = clean_d & ~clean_q;
    fall_d    = ~clean_d & clean_q;
    pending_d = (pending_q & ~bus.clear)
              | (rise_d & bus.rise_en)
              | (fall_d & bus.fall_en);
    irq_d     = |(pending_d & bus.irq_mask);
  end

  // State registers; reset aligns sync and clean so no edge follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q     <= '0;
      clean_q   <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.clean   = clean_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.pending = pending_q;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus a random run
// against a sliding-window reference model.
module tb_debounce_bank;

  localparam int C  = 4;
  localparam int SS = 2;
  localparam int SC = 4;
  localparam logic [C-1:0] RV = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  debounce_bank_if #(.CHANNELS(C)) bus();

  debounce_bank #(
    .CHANNELS(C),
    .SYNC_STAGES(SS),
    .STABLE_CYCLES(SC),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: clean flips once the last SC filter samples all differ from it;
  // filter sample at edge k is dirty as sampled SS edges earlier.
  logic [C-1:0] dq[$];
  logic [C-1:0] m_clean, m_rise, m_fall, m_pend;
  logic         m_irq;

  task automatic model_reset();
    m_clean = RV;
    m_rise  = '0;
    m_fall  = '0;
    m_pend  = '0;
    m_irq   = 1'b0;
    dq.delete();
    repeat (SS + SC) dq.push_back(RV);
  endtask

  task automatic model_edge(input logic [C-1:0] d, re, fe, msk, clr);
    logic [C-1:0] nc;
    logic [C-1:0] v;
    bit all_diff;
    dq.push_back(d);
    if (dq.size() > SS + SC) void'(dq.pop_front());
    nc = m_clean;
    for (int c = 0; c < C; c++) begin
      all_diff = 1;
      for (int i = 0; i < SC; i++) begin
        v = dq[i];
        if (v[c] == m_clean[c]) all_diff = 0;
      end
      if (all_diff) nc[c] = ~m_clean[c];
    end
    m_rise  = nc & ~m_clean;
    m_fall  = ~nc & m_clean;
    m_pend  = (m_pend & ~clr) | (m_rise & re) | (m_fall & fe);
    m_irq   = |(m_pend & msk);
    m_clean = nc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge(bus.dirty, bus.rise_en, bus.fall_en,
                         bus.irq_mask, bus.clear);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    bus.dirty    = '0;
    bus.rise_en  = '0;
    bus.fall_en  = '0;
    bus.irq_mask = '0;
    bus.clear    = '0;
    tick();
    tick();
    total++;
    if ({bus.clean, bus.rise, bus.fall, bus.pending, bus.irq} !== 17'b0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=0",
               {bus.clean, bus.rise, bus.fall, bus.pending, bus.irq});
    end
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.clean, bus.rise, bus.fall, bus.pending, bus.irq} !== 17'b0) begin
      bad++;
      $display("FAIL reset_release got=%b exp=0",
               {bus.clean, bus.rise, bus.fall, bus.pending, bus.irq});
    end
  endtask

  task automatic test_clean_rise();
    bus.rise_en  = 4'b1001;
    bus.fall_en  = 4'b0000;
    bus.irq_mask = 4'b0001;
    bus.dirty    = 4'b0001;
    for (int e = 1; e <= 5; e++) begin
      tick();
      total++;
      if ({bus.clean, bus.rise, bus.pending, bus.irq} !== 13'b0) begin
        bad++;
        $display("FAIL rise_early e%0d clean=%b rise=%b pend=%b irq=%b exp=0",
                 e, bus.clean, bus.rise, bus.pending, bus.irq);
      end
    end
    tick();
    total++;
    if (bus.clean !== 4'b0001 || bus.rise !== 4'b0001 ||
        bus.pending !== 4'b0001 || bus.irq !== 1'b1) begin
      bad++;
      $display("FAIL rise_e6 clean=%b rise=%b pend=%b irq=%b exp=0001/0001/0001/1",
               bus.clean, bus.rise, bus.pending, bus.irq);
    end
    tick();
    total++;
    if (bus.rise !== 4'b0000 || bus.clean !== 4'b0001) begin
      bad++;
      $display("FAIL rise_e7 rise=%b clean=%b exp=0000/0001",
               bus.rise, bus.clean);
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    pat = 9'b111110111;
    for (int e = 1; e <= 9; e++) begin
      bus.dirty[1] = pat[e-1];
      tick();
      total++;
      if (bus.clean[1] !== 1'b0 || bus.rise[1] !== 1'b0) begin
        bad++;
        $display("FAIL bounce_early e%0d clean1=%b rise1=%b exp=0/0",
                 e, bus.clean[1], bus.rise[1]);
      end
    end
    tick();
    total++;
    if (bus.clean[1] !== 1'b1 || bus.rise[1] !== 1'b1 ||
        bus.pending[1] !== 1'b0) begin
      bad++;
      $display("FAIL bounce_accept clean1=%b rise1=%b pend1=%b exp=1/1/0",
               bus.clean[1], bus.rise[1], bus.pending[1]);
    end
  endtask

  task automatic test_fall_disabled();
    bus.fall_en  = 4'b1011;
    bus.dirty[2] = 1'b1;
    repeat (6) tick();
    total++;
    if (bus.clean[2] !== 1'b1 || bus.rise[2] !== 1'b1 ||
        bus.pending[2] !== 1'b0) begin
      bad++;
      $display("FAIL fall_setup clean2=%b rise2=%b pend2=%b exp=1/1/0",
               bus.clean[2], bus.rise[2], bus.pending[2]);
    end
    bus.dirty[2] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      total++;
      if (bus.fall[2] !== 1'b0) begin
        bad++;
        $display("FAIL fall_early e%0d fall2=%b exp=0", e, bus.fall[2]);
      end
    end
    tick();
    total++;
    if (bus.fall[2] !== 1'b1 || bus.clean[2] !== 1'b0 ||
        bus.pending[2] !== 1'b0 || bus.irq !== 1'b1) begin
      bad++;
      $display("FAIL fall_disabled fall2=%b clean2=%b pend2=%b irq=%b exp=1/0/0/1",
               bus.fall[2], bus.clean[2], bus.pending[2], bus.irq);
    end
  endtask

  task automatic test_clear_collision();
    bus.dirty[0] = 1'b0;
    repeat (6) tick();
    total++;
    if (bus.fall[0] !== 1'b1 || bus.pending[0] !== 1'b1) begin
      bad++;
      $display("FAIL clr_fall fall0=%b pend0=%b exp=1/1",
               bus.fall[0], bus.pending[0]);
    end
    bus.dirty[0] = 1'b1;
    repeat (5) tick();
    bus.clear = 4'b0001;
    tick();
    total++;
    if (bus.rise[0] !== 1'b1 || bus.pending[0] !== 1'b1 || bus.irq !== 1'b1) begin
      bad++;
      $display("FAIL clr_collide rise0=%b pend0=%b irq=%b exp=1/1/1",
               bus.rise[0], bus.pending[0], bus.irq);
    end
    tick();
    total++;
    if (bus.pending !== 4'b0000 || bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL clr_alone pend=%b irq=%b exp=0000/0",
               bus.pending, bus.irq);
    end
    bus.clear = 4'b0000;
  endtask

  task automatic test_mask();
    bus.irq_mask = 4'b0001;
    bus.dirty[3] = 1'b1;
    repeat (6) tick();
    total++;
    if (bus.pending[3] !== 1'b1 || bus.rise[3] !== 1'b1 || bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL mask_off pend3=%b rise3=%b irq=%b exp=1/1/0",
               bus.pending[3], bus.rise[3], bus.irq);
    end
    bus.irq_mask = 4'b1001;
    #1;
    total++;
    if (bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL mask_comb irq=%b exp=0", bus.irq);
    end
    tick();
    total++;
    if (bus.irq !== 1'b1) begin
      bad++;
      $display("FAIL mask_on irq=%b exp=1", bus.irq);
    end
    bus.clear = 4'b1000;
    tick();
    total++;
    if (bus.pending !== 4'b0000 || bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL mask_clear pend=%b irq=%b exp=0000/0",
               bus.pending, bus.irq);
    end
    bus.clear = 4'b0000;
  endtask

  task automatic test_reset_midcount();
    bus.dirty[0] = 1'b0;
    repeat (4) tick();
    total++;
    if (bus.clean[0] !== 1'b1) begin
      bad++;
      $display("FAIL midcount_pre clean0=%b exp=1", bus.clean[0]);
    end
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({bus.clean, bus.rise, bus.fall, bus.pending, bus.irq} !== 17'b0) begin
      bad++;
      $display("FAIL midcount_rst got=%b exp=0",
               {bus.clean, bus.rise, bus.fall, bus.pending, bus.irq});
    end
    bus.dirty    = '0;
    bus.rise_en  = '1;
    bus.fall_en  = '1;
    bus.irq_mask = '1;
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++;
      if ({bus.clean, bus.rise, bus.fall, bus.pending, bus.irq} !== 17'b0) begin
        bad++;
        $display("FAIL midcount_post e%0d got=%b exp=0", e,
                 {bus.clean, bus.rise, bus.fall, bus.pending, bus.irq});
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] got, exp;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 5) == 0) bus.dirty[c] = ~bus.dirty[c];
      end
      bus.clear = ($urandom_range(0, 7) == 0) ? C'($urandom) : '0;
      if (n % 64 == 0) begin
        bus.rise_en  = C'($urandom);
        bus.fall_en  = C'($urandom);
        bus.irq_mask = C'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({bus.clean, bus.rise, bus.fall, bus.pending, bus.irq} !== 17'b0) begin
          bad++;
          $display("FAIL rand_rst n=%0d got=%b exp=0", n,
                   {bus.clean, bus.rise, bus.fall, bus.pending, bus.irq});
        end
        tick();
        rst = 1'b0;
      end
      tick();
      got = {bus.clean, bus.rise, bus.fall, bus.pending, bus.irq};
      exp = {m_clean, m_rise, m_fall, m_pend, m_irq};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rand n=%0d got=%b exp=%b (clean,rise,fall,pend,irq)",
                 n, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_fall_disabled();
    test_clear_collision();
    test_mask();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
